mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Shares the single byte-wide external memory port (uio bus plus toggle handshake) between two requesters: port 0 is the CPU core, port 1 is the debug/DMA loader.
- Arbitrates round-robin and locks the grant for a whole transaction.
- Sequences each transaction as three handshake beats: address low, address high, then data.
- Sits between the requesters and the top-level pins. It replaces the memory sequencer that currently lives inside the CPU top.

Parameters:
- ADDR_W, 16, requester address width; must be 16 (two address beats).
- DATA_W, 8, bus and data width.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- m0_read  in  1  port 0 read request, level, held until m0_done
- m0_write  in  1  port 0 write request, level, held until m0_done
- m0_addr  in  16  port 0 address, stable while requesting
- m0_wdata  in  8  port 0 write data, stable while requesting
- m0_rdata  out  8  port 0 read data, valid from m0_done onward
- m0_done  out  1  port 0 one-cycle completion pulse
- m1_read, m1_write, m1_addr, m1_wdata, m1_rdata, m1_done  same as port 0, for port 1
- bus_in  in  8  pin data in (uio_in)
- bus_out  out  8  pin data out (uio_out)
- bus_oe  out  8  pin output enable, all ones or all zeros
- hs_in  in  1  external handshake in (ui_in[0])
- hs_out  out  1  handshake out to pin, registered
- bus_rd  out  1  status: read transaction in progress
- bus_wr  out  1  status: write transaction in progress
- bus_owner  out  1  granted port; meaningful only while bus_rd or bus_wr is high

Behaviour:
- Reset (async) values:
  - State IDLE, beat sub-state WAIT_LOW.
  - hs_out=0, bus_oe=0, bus_out=0.
  - m0_done=m1_done=0, m0_rdata=m1_rdata=0.
  - bus_rd=bus_wr=0, last_grant=1, so port 0 wins the first tie.
- Reset asserted mid-transaction abandons it silently; no done is issued.
- A port requests when its read or write is high. If read and write are both high, the transaction is a write.
- Arbitration happens only in IDLE, evaluated every cycle:
  - Only one port requesting: that port is granted.
  - Both requesting: the port != last_grant is granted.
  - Grant, direction, address and wdata are registered on the grant edge and are ignored afterwards.
  - A port whose done is high this cycle is masked from arbitration in that cycle.
- Main state machine IDLE -> ADDR_LO -> ADDR_HI -> DATA -> IDLE; each non-IDLE state advances when its beat completes.
  - ADDR_LO: bus_oe=FF, bus_out=addr[7:0].
  - ADDR_HI: bus_oe=FF, bus_out=addr[15:8].
  - DATA, write: bus_oe=FF, bus_out=wdata.
  - DATA, read: bus_oe=00.
  - IDLE: bus_oe=00.
- Beat engine, per phase:
  - WAIT_LOW: wait for hs_in=0.
  - DRIVE: hs_out<=1 on the next edge.
  - Once hs_out=1 and hs_in=1, the beat completes: hs_out<=0, sub-state returns to WAIT_LOW.
  - hs_in already low at phase entry costs no extra wait.
- On DATA beat completion:
  - Read: bus_in is captured into the granted port's rdata.
  - Either direction: the granted done is pulsed on the following cycle, last_grant<=owner, state<=IDLE.
- rdata holds until that port's next read completes.
- Latency with an instantly responding partner is 3 beats x 2 cycles plus 1 cycle grant = 7 cycles from request to done.
- bus_rd/bus_wr are high from the grant edge until the done edge.
- Bus data must be stable while hs_out=1; the partner samples on its rising view of hs_out.
- hs_in stuck high never completes a beat. There is no timeout; the block waits forever.

Optional Feature:
- Macro: MEM_BUS_HS_SYNC_EN.
- Defined: hs_in passes a two-flop synchroniser, reset 1, before the beat engine. Each beat costs 2 extra cycles per hs_in edge.
- Undefined: hs_in is used directly, with timing as above.

Decomposition:
- Package mem_bus_pkg:
  - Phase enum IDLE/ADDR_LO/ADDR_HI/DATA.
  - Beat enum WAIT_LOW/DRIVE.
  - OE_ALL=8'hFF, OE_NONE=8'h00.
- Sub-module mem_hs_beat:
  - Inputs: clk, rst_n, start/valid, hs_in.
  - Outputs: hs_out, beat_done pulse.
  - Contains the optional synchroniser.
  - The arbiter FSM instantiates it once.

Test Plan:
- Port 0 read at 0x1234, partner instant, bus_in=0x5A in data beat -> bus_out 0x34 then 0x12 with oe=FF; m0_done 7 cycles after request; m0_rdata=0x5A.
- Port 1 write 0xC3 to 0xBEEF -> beats 0xEF, 0xBE, 0xC3, all with oe=FF; m1_done pulses once; m0_done stays 0.
- Both ports request from reset -> port 0 served first, then port 1. Both held continuously -> grants alternate 0,1,0,1.
- Partner delays hs_in rise by 10 cycles on ADDR_HI -> hs_out stays 1 and bus_out stays addr[15:8] throughout; done delayed by exactly 10 cycles.
- rst_n pulsed low during DATA -> hs_out=0, oe=0, no done; a fresh request after reset completes normally.
- With MEM_BUS_HS_SYNC_EN defined, repeat the first scenario -> identical data, done at 7+12=19 cycles.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// rtl/mem_bus_pkg.sv - shared types and constants for the memory bus arbiter
package mem_bus_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ADDR_LO = 2'd1,
    ADDR_HI = 2'd2,
    DATA    = 2'd3
  } phase_t;

  typedef enum logic {
    WAIT_LOW = 1'b0,
    DRIVE    = 1'b1
  } beat_t;

  localparam logic [7:0] OE_ALL  = 8'hFF;
  localparam logic [7:0] OE_NONE = 8'h00;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// rtl/mem_bus_arbiter_if.sv - pin-side byte bus, toggle handshake and status signals
interface mem_bus_arbiter_if;
  logic [7:0] bus_in;
  logic [7:0] bus_out;
  logic [7:0] bus_oe;
  logic       hs_in;
  logic       hs_out;
  logic       bus_rd;
  logic       bus_wr;
  logic       bus_owner;

  modport master (
    input  bus_in, hs_in,
    output bus_out, bus_oe, hs_out, bus_rd, bus_wr, bus_owner
  );

  modport slave (
    output bus_in, hs_in,
    input  bus_out, bus_oe, hs_out, bus_rd, bus_wr, bus_owner
  );
endinterface

// File: rtl/mem_hs_beat.sv
// rtl/mem_hs_beat.sv - one handshake beat engine; MEM_BUS_HS_SYNC_EN adds a 2-flop hs_in synchroniser
module mem_hs_beat
  import mem_bus_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic hs_in,
  output logic hs_out,
  output logic beat_done
);

  beat_t state_q, state_d;
  logic  hs_s;

`ifdef MEM_BUS_HS_SYNC_EN
  logic [1:0] sync_q;

  // Resets high so a partner still asserting after reset is not seen as low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b11;
    else        sync_q <= {sync_q[0], hs_in};
  end

  assign hs_s = sync_q[1];
`else
  assign hs_s = hs_in;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= WAIT_LOW;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT_LOW: if (start && !hs_s) state_d = DRIVE;
      DRIVE:    if (hs_s)           state_d = WAIT_LOW;
      default:                      state_d = WAIT_LOW;
    endcase
  end

  // hs_out is the DRIVE flop itself, so the pin is glitch-free.
  always_comb begin
    hs_out    = (state_q == DRIVE);
    beat_done = start && (state_q == DRIVE) && hs_s;
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - round-robin arbiter sequencing two requesters onto the byte-wide memory port
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_done,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_done,
  mem_bus_arbiter_if.master bus
);

  phase_t            state_q, state_d;
  logic              owner_q, wr_q, last_grant_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, rdata0_q, rdata1_q;
  logic [1:0]        done_q;
  logic              bus_rd_q, bus_wr_q;

  logic              req0, req1, gnt_valid, gnt_port, gnt_wr;
  logic              beat_start, beat_done, hs_out;
  logic [7:0]        bus_out_d, bus_oe_d;

  // A port still showing its done pulse is not a fresh request.
  assign req0      = (m0_read || m0_write) && !done_q[0];
  assign req1      = (m1_read || m1_write) && !done_q[1];
  assign gnt_valid = req0 || req1;

  always_comb begin
    gnt_port = req1;
    if (req0 && req1) gnt_port = !last_grant_q;
    gnt_wr = gnt_port ? m1_write : m0_write;
  end

  assign beat_start = (state_q != IDLE);

  mem_hs_beat u_beat (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (beat_start),
    .hs_in     (bus.hs_in),
    .hs_out    (hs_out),
    .beat_done (beat_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (gnt_valid) state_d = ADDR_LO;
      ADDR_LO: if (beat_done) state_d = ADDR_HI;
      ADDR_HI: if (beat_done) state_d = DATA;
      DATA:    if (beat_done) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_comb begin
    bus_oe_d  = OE_NONE;
    bus_out_d = 8'h00;
    case (state_q)
      ADDR_LO: begin bus_oe_d = OE_ALL; bus_out_d = addr_q[7:0];  end
      ADDR_HI: begin bus_oe_d = OE_ALL; bus_out_d = addr_q[15:8]; end
      DATA:    if (wr_q) begin bus_oe_d = OE_ALL; bus_out_d = wdata_q; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q      <= 1'b0;
      wr_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
      done_q       <= 2'b00;
      bus_rd_q     <= 1'b0;
      bus_wr_q     <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      done_q <= 2'b00;
      if (state_q == IDLE && gnt_valid) begin
        owner_q  <= gnt_port;
        wr_q     <= gnt_wr;
        addr_q   <= gnt_port ? m1_addr  : m0_addr;
        wdata_q  <= gnt_port ? m1_wdata : m0_wdata;
        bus_rd_q <= !gnt_wr;
        bus_wr_q <= gnt_wr;
      end
      if (state_q == DATA && beat_done) begin
        if (!wr_q) begin
          if (owner_q) rdata1_q <= bus.bus_in;
          else         rdata0_q <= bus.bus_in;
        end
        done_q[owner_q] <= 1'b1;
        last_grant_q    <= owner_q;
        bus_rd_q        <= 1'b0;
        bus_wr_q        <= 1'b0;
      end
    end
  end

  assign m0_rdata      = rdata0_q;
  assign m1_rdata      = rdata1_q;
  assign m0_done       = done_q[0];
  assign m1_done       = done_q[1];
  assign bus.bus_out   = bus_out_d;
  assign bus.bus_oe    = bus_oe_d;
  assign bus.hs_out    = hs_out;
  assign bus.bus_rd    = bus_rd_q;
  assign bus.bus_wr    = bus_wr_q;
  assign bus.bus_owner = owner_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - directed bench for mem_bus_arbiter with a scripted handshake partner
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m0_read = 1'b0, m0_write = 1'b0, m1_read = 1'b0, m1_write = 1'b0;
  logic [15:0] m0_addr = '0, m1_addr = '0;
  logic [7:0]  m0_wdata = '0, m1_wdata = '0;
  logic [7:0]  m0_rdata, m1_rdata;
  logic        m0_done, m1_done;

  mem_bus_arbiter_if bus_if ();

  mem_bus_arbiter dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .m0_read  (m0_read),
    .m0_write (m0_write),
    .m0_addr  (m0_addr),
    .m0_wdata (m0_wdata),
    .m0_rdata (m0_rdata),
    .m0_done  (m0_done),
    .m1_read  (m1_read),
    .m1_write (m1_write),
    .m1_addr  (m1_addr),
    .m1_wdata (m1_wdata),
    .m1_rdata (m1_rdata),
    .m1_done  (m1_done),
    .bus      (bus_if)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  int          d0 = 0, d1 = 0;
  int          beat_no = 0, stall_beat = -1, stall_left = 0, unstable = 0;
  bit          seen = 1'b0;
  logic [7:0]  cap = '0;
  logic [15:0] beat_log[$];

  initial begin
    bus_if.hs_in  = 1'b0;
    bus_if.bus_in = 8'h00;
  end

  // Partner: answers hs_out within the same cycle unless told to stall a beat.
  always @(negedge clk) begin
    if (!bus_if.hs_out) begin
      bus_if.hs_in = 1'b0;
      seen = 1'b0;
    end else if (!bus_if.hs_in) begin
      if (!seen) begin
        seen = 1'b1;
        cap  = bus_if.bus_out;
      end else if (bus_if.bus_out !== cap) begin
        unstable++;
      end
      if (beat_no == stall_beat && stall_left > 0) begin
        stall_left--;
      end else begin
        bus_if.hs_in = 1'b1;
        beat_log.push_back({bus_if.bus_oe, bus_if.bus_out});
        beat_no++;
      end
    end
  end

  always @(negedge clk) begin
    if (m0_done) d0++;
    if (m1_done) d1++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_txn(input bit port, input bit wr, input logic [15:0] a, input logic [7:0] d,
                         output int lat, output logic [2:0] st);
    bit got;
    got = 1'b0;
    lat = 0;
    st  = '0;
    @(negedge clk);
    if (port) begin
      m1_addr = a; m1_wdata = d; m1_write = wr; m1_read = !wr;
    end else begin
      m0_addr = a; m0_wdata = d; m0_write = wr; m0_read = !wr;
    end
    while (!got && lat < 300) begin
      @(negedge clk);
      lat++;
      if (lat == 1) st = {bus_if.bus_rd, bus_if.bus_wr, bus_if.bus_owner};
      got = port ? m1_done : m0_done;
    end
    if (port) begin m1_read = 1'b0; m1_write = 1'b0; end
    else      begin m0_read = 1'b0; m0_write = 1'b0; end
    check("txn_timeout", {31'b0, got}, 32'h1);
  endtask

  task automatic new_txn();
    beat_log.delete();
    beat_no    = 0;
    stall_beat = -1;
    stall_left = 0;
    unstable   = 0;
  endtask

  int          lat, lat_w, cnt, s0, s1;
  logic [2:0]  st;
  bit          owners[$];

  initial begin
    repeat (3) @(negedge clk);
    check("rst_hs_out", bus_if.hs_out, 0);
    check("rst_oe", bus_if.bus_oe, 8'h00);
    check("rst_bus_out", bus_if.bus_out, 8'h00);
    check("rst_done", {m1_done, m0_done}, 0);
    check("rst_rdata", {m1_rdata, m0_rdata}, 16'h0000);
    check("rst_rd_wr", {bus_if.bus_rd, bus_if.bus_wr}, 0);
    rst_n = 1'b1;

    // Port 0 read of 0x1234 returning 0x5A.
    new_txn();
    bus_if.bus_in = 8'h5A;
    run_txn(1'b0, 1'b0, 16'h1234, 8'h00, lat, st);
`ifndef MEM_BUS_HS_SYNC_EN
    check("rd_latency", lat, 7);
`endif
    check("rd_status", st, 3'b100);
    check("rd_beats", beat_log.size(), 3);
    if (beat_log.size() == 3) begin
      check("rd_addr_lo", beat_log[0], 16'hFF34);
      check("rd_addr_hi", beat_log[1], 16'hFF12);
      check("rd_data_oe", beat_log[2][15:8], 8'h00);
    end
    check("rd_rdata", m0_rdata, 8'h5A);
    @(posedge clk); #1;
    check("rd_status_end", {bus_if.bus_rd, bus_if.bus_wr}, 0);

    // Port 1 write 0xC3 to 0xBEEF.
    s0 = d0; s1 = d1;
    new_txn();
    bus_if.bus_in = 8'h99;
    run_txn(1'b1, 1'b1, 16'hBEEF, 8'hC3, lat_w, st);
`ifndef MEM_BUS_HS_SYNC_EN
    check("wr_latency", lat_w, 7);
`endif
    check("wr_status", st, 3'b011);
    check("wr_beats", beat_log.size(), 3);
    if (beat_log.size() == 3) begin
      check("wr_addr_lo", beat_log[0], 16'hFFEF);
      check("wr_addr_hi", beat_log[1], 16'hFFBE);
      check("wr_data", beat_log[2], 16'hFFC3);
    end
    repeat (4) @(posedge clk); #1;
    check("wr_m1_done_once", d1 - s1, 1);
    check("wr_m0_done_quiet", d0 - s0, 0);
    check("rdata_hold", m0_rdata, 8'h5A);

    // Both ports from reset, held for four transactions.
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    new_txn();
    owners.delete();
    m0_addr = 16'h0100; m1_addr = 16'h0200;
    m0_read = 1'b1; m1_read = 1'b1;
    cnt = 0;
    while (owners.size() < 4 && cnt < 200) begin
      @(negedge clk);
      cnt++;
      if (m0_done) owners.push_back(1'b0);
      if (m1_done) owners.push_back(1'b1);
    end
    m0_read = 1'b0; m1_read = 1'b0;
    repeat (20) @(negedge clk);
    check("alt_count", owners.size(), 4);
    if (owners.size() == 4) begin
      check("alt_0", owners[0], 0);
      check("alt_1", owners[1], 1);
      check("alt_2", owners[2], 0);
      check("alt_3", owners[3], 1);
    end
    check("alt_idle", {bus_if.bus_rd, bus_if.bus_wr}, 0);

    // Partner holds off the address-high beat for 10 cycles.
    new_txn();
    stall_beat = 1;
    stall_left = 10;
    run_txn(1'b0, 1'b1, 16'hA55A, 8'h77, lat, st);
    check("stall_latency", lat, lat_w + 10);
    check("stall_stable", unstable, 0);
    if (beat_log.size() == 3) check("stall_addr_hi", beat_log[1], 16'hFFA5);
    else check("stall_beats", beat_log.size(), 3);

    // Reset while the data beat is being driven.
    new_txn();
    stall_beat = 2;
    stall_left = 5;
    @(negedge clk);
    m0_addr = 16'h4321; m0_read = 1'b1;
    cnt = 0;
    while (!(beat_log.size() == 2 && bus_if.hs_out) && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    check("rst_mid_reach", {31'b0, cnt < 100}, 1);
    s0 = d0;
    rst_n = 1'b0;
    m0_read = 1'b0;
    #1;
    check("rst_mid_hs_out", bus_if.hs_out, 0);
    check("rst_mid_oe", bus_if.bus_oe, 8'h00);
    check("rst_mid_status", {bus_if.bus_rd, bus_if.bus_wr}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    stall_left = 0;
    repeat (10) @(posedge clk); #1;
    check("rst_mid_no_done", d0 - s0, 0);
    check("rst_mid_rdata", m0_rdata, 8'h00);

    new_txn();
    bus_if.bus_in = 8'h3C;
    run_txn(1'b0, 1'b0, 16'h0001, 8'h00, lat, st);
`ifndef MEM_BUS_HS_SYNC_EN
    check("post_rst_latency", lat, 7);
`endif
    check("post_rst_rdata", m0_rdata, 8'h3C);
    if (beat_log.size() == 3) check("post_rst_addr_lo", beat_log[0], 16'hFF01);
    else check("post_rst_beats", beat_log.size(), 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
